// File: rtl/usrclk_active_monitor.sv
// usrclk_active_monitor: per-channel GT user-clock activity monitor over fixed clk windows.
// Define USRCLK_MON_FREQ_CHECK_EN to qualify windows on MIN_EDGES..MAX_EDGES instead of any edge.
module usrclk_active_monitor #(
    parameter int NUM_CH         = 4,
    parameter int WINDOW         = 1024,
    parameter int STABLE_WINDOWS = 4,
    parameter int MIN_EDGES      = 1,
    parameter int MAX_EDGES      = WINDOW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] clk_toggle,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic [NUM_CH-1:0] ch_active,
    output logic              all_active,
    output logic [NUM_CH-1:0] lost_pulse
);
    localparam int WW = $clog2(WINDOW);
`ifdef USRCLK_MON_FREQ_CHECK_EN
    localparam int CW = $clog2(WINDOW + 1);
`else
    localparam int CW = 1;
`endif
    localparam int GW = $clog2(STABLE_WINDOWS + 1);
    typedef enum logic [1:0] {LOST, CHECK, ACTIVE} state_t;
    (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] r_sync1;
    (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] r_sync2;
    logic [NUM_CH-1:0] r_sync3;
    logic [NUM_CH-1:0] r_part;
    logic [WW-1:0]     r_win;
    logic [CW-1:0]     r_cnt [NUM_CH];
    logic [CW-1:0]     w_cnt [NUM_CH];
    logic [GW-1:0]     r_good [NUM_CH];
    logic [GW-1:0]     w_good_nx [NUM_CH];
    state_t            r_state [NUM_CH];
    state_t            w_state_nx [NUM_CH];
    logic [NUM_CH-1:0] w_edge, w_ok, w_act_nx, w_lost_nx;
    logic              w_win_end;
    assign w_edge    = r_sync2 ^ r_sync3;
    assign w_win_end = r_win == WW'(WINDOW - 1);
    // r_part marks a window in which the channel was disabled at some point; such a window is never good
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_cnt[i] = &r_cnt[i] ? r_cnt[i] : r_cnt[i] + CW'(w_edge[i]);
`ifdef USRCLK_MON_FREQ_CHECK_EN
            w_ok[i] = !r_part[i] && w_cnt[i] >= CW'(MIN_EDGES) && w_cnt[i] <= CW'(MAX_EDGES);
`else
            w_ok[i] = !r_part[i] && w_cnt[i] != '0;
`endif
            w_state_nx[i] = r_state[i];
            w_good_nx[i]  = r_good[i];
            if (!ch_enable[i]) begin
                w_state_nx[i] = LOST;
                w_good_nx[i]  = '0;
            end else if (w_win_end) begin
                if (!w_ok[i]) begin
                    w_state_nx[i] = LOST;
                    w_good_nx[i]  = '0;
                end else if (r_state[i] != ACTIVE) begin
                    w_good_nx[i]  = r_good[i] + 1'b1;
                    w_state_nx[i] = (w_good_nx[i] == GW'(STABLE_WINDOWS)) ? ACTIVE : CHECK;
                end
            end
            w_act_nx[i]  = w_state_nx[i] == ACTIVE;
            w_lost_nx[i] = ch_enable[i] && r_state[i] == ACTIVE && w_state_nx[i] == LOST;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync3    <= '0;
            r_part     <= '0;
            r_win      <= '0;
            ch_active  <= '0;
            all_active <= 1'b0;
            lost_pulse <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]   <= '0;
                r_good[i]  <= '0;
                r_state[i] <= LOST;
            end
        end else begin
            r_sync1    <= clk_toggle;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            r_part     <= w_win_end ? '0 : r_part | ~ch_enable;
            r_win      <= w_win_end ? '0 : r_win + 1'b1;
            ch_active  <= w_act_nx;
            all_active <= |ch_enable && &(w_act_nx | ~ch_enable);
            lost_pulse <= w_lost_nx;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]   <= (w_win_end || !ch_enable[i]) ? '0 : w_cnt[i];
                r_good[i]  <= w_good_nx[i];
                r_state[i] <= w_state_nx[i];
            end
        end
    end
endmodule

// File: tb/tb_usrclk_active_monitor.sv
// tb_usrclk_active_monitor: random-period toggle stimulus checked every cycle against a window-level model.
module tb_usrclk_active_monitor;
    localparam int NCH = 2, WIN = 16, STB = 2, MINE = 4, MAXE = 12;
    logic clk = 1'b0, rst = 1'b1;
    logic [NCH-1:0] tog = '0, en = '0;
    logic [NCH-1:0] ch_active, lost_pulse;
    logic all_active;
    int vectors = 0, errors = 0;
    int per[NCH], tcnt[NCH];
    int m_pos, m_edges[NCH], m_streak[NCH];
    bit m_full[NCH];
    logic [NCH-1:0] m_h0, m_h1, m_h2, m_act, m_lost;
    logic m_all;
    usrclk_active_monitor #(
        .NUM_CH(NCH), .WINDOW(WIN), .STABLE_WINDOWS(STB), .MIN_EDGES(MINE), .MAX_EDGES(MAXE)
    ) dut (
        .clk(clk), .rst(rst), .clk_toggle(tog), .ch_enable(en),
        .ch_active(ch_active), .all_active(all_active), .lost_pulse(lost_pulse)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic bit edges_ok(input int n);
`ifdef USRCLK_MON_FREQ_CHECK_EN
        return n >= MINE && n <= MAXE;
`else
        return n >= 1;
`endif
    endfunction
    // Window-level model: a channel is active once its run of good, fully-enabled windows reaches STB;
    // toggle changes become visible to the edge detector two clk cycles after being sampled.
    task automatic model_step();
        bit good;
        if (rst) begin
            m_pos = 0;
            m_h0 = '0; m_h1 = '0; m_h2 = '0;
            m_act = '0; m_lost = '0; m_all = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_edges[i] = 0; m_streak[i] = 0; m_full[i] = 1'b1;
            end
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            m_lost[i] = 1'b0;
            if (!en[i]) begin
                m_edges[i] = 0; m_streak[i] = 0;
            end else begin
                m_edges[i] += int'(m_h1[i] ^ m_h2[i]);
                if (m_pos == WIN - 1) begin
                    good = m_full[i] && edges_ok(m_edges[i]);
                    m_lost[i] = m_streak[i] >= STB && !good;
                    m_streak[i] = good ? m_streak[i] + 1 : 0;
                    m_edges[i] = 0;
                end
            end
            if (m_pos == WIN - 1) m_full[i] = 1'b1;
            else if (!en[i]) m_full[i] = 1'b0;
            m_act[i] = en[i] && m_streak[i] >= STB;
        end
        m_h2 = m_h1; m_h1 = m_h0; m_h0 = tog;
        m_all = |en && ((m_act | ~en) == '1);
        m_pos = (m_pos + 1) % WIN;
    endtask
    task automatic step();
        @(negedge clk);
        model_step();
        check("ch_active", 32'(ch_active), 32'(m_act));
        check("all_active", 32'(all_active), 32'(m_all));
        check("lost_pulse", 32'(lost_pulse), 32'(m_lost));
        for (int i = 0; i < NCH; i++) begin
            if (per[i] != 0) begin
                tcnt[i]++;
                if (tcnt[i] >= per[i]) begin
                    tcnt[i] = 0;
                    tog[i] = ~tog[i];
                end
            end
        end
    endtask
    task automatic run(input int n);
        repeat (n) step();
    endtask
    initial begin
        int n, pulses;
        for (int i = 0; i < NCH; i++) begin
            per[i] = 0;
            tcnt[i] = 0;
        end
        run(3);
        check("rst_outputs", 32'({ch_active, lost_pulse, all_active}), 32'd0);
        rst = 1'b0; en = 2'b01; per[0] = 2; tcnt[0] = int'($urandom_range(0, 1));
        run(3 * WIN);
        check("one_ch_active", 32'(ch_active), 32'd1);
        check("one_ch_all", 32'(all_active), 32'd1);
        per[0] = 0; pulses = 0;
        for (int k = 0; k < 3 * WIN; k++) begin
            step();
            pulses += int'(lost_pulse[0]);
        end
        check("stop_pulses", 32'(pulses), 32'd1);
        check("stop_inactive", 32'(ch_active[0]), 32'd0);
        per[0] = 1;
        run(4 * WIN);
`ifdef USRCLK_MON_FREQ_CHECK_EN
        check("overfreq", 32'(ch_active[0]), 32'd0);
`else
        check("overfreq", 32'(ch_active[0]), 32'd1);
`endif
        per[0] = 2; per[1] = 2; en = 2'b11;
        run(4 * WIN);
        check("both_active", 32'(ch_active), 32'd3);
        en[1] = 1'b0;
        step();
        check("dis_active1", 32'(ch_active[1]), 32'd0);
        check("dis_lost1", 32'(lost_pulse[1]), 32'd0);
        check("dis_all", 32'(all_active), 32'd1);
        en = 2'b11;
        run(3 * WIN + 5);
        check("reen_active", 32'(ch_active), 32'd3);
        run(int'($urandom_range(1, 10)));
        rst = 1'b1;
        step();
        check("midrst_outputs", 32'({ch_active, lost_pulse, all_active}), 32'd0);
        rst = 1'b0; n = 1;
        while (ch_active != 2'b11 && n < 100) begin
            step();
            n++;
        end
        check("rst_reacq", 32'(n), 32'(2 * WIN + 1));
        en = 2'b01; per[0] = 0;
        run(3 * WIN);
        while (m_pos != 0) step();
        per[0] = 2; tcnt[0] = 0;
        run(12);
        per[0] = 0;
        run(4);
        check("seq_good1", 32'(ch_active[0]), 32'd0);
        run(WIN);
        check("seq_bad", 32'(ch_active[0]), 32'd0);
        per[0] = 2; tcnt[0] = 0;
        run(WIN);
        check("seq_good2", 32'(ch_active[0]), 32'd0);
        run(WIN - 1);
        check("seq_pre_active", 32'(ch_active[0]), 32'd0);
        step();
        check("seq_active", 32'(ch_active[0]), 32'd1);
        for (int w = 0; w < 25; w++) begin
            for (int i = 0; i < NCH; i++) begin
                per[i] = int'($urandom_range(0, 5));
                if ($urandom_range(0, 5) == 0) en[i] = ~en[i];
            end
            if ($urandom_range(0, 11) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            run(int'($urandom_range(WIN - 4, WIN + 4)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/usrclk_active_monitor.md
USRCLK_ACTIVE_MONITOR -- requirements
Module: usrclk_active_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of monitored GT user-clock channels (1..32).
REQ-002 SHALL have parameter WINDOW, default 1024, measurement window length in clk cycles (>=4).
REQ-003 SHALL have parameter STABLE_WINDOWS, default 4, consecutive good windows required to declare a channel active (>=1).
REQ-004 SHALL have parameter MIN_EDGES, default 1, minimum toggle edges per good window.
REQ-005 SHALL have parameter MAX_EDGES, default WINDOW, maximum toggle edges per good window.
REQ-006 SHALL have port clk  input  1  free-running monitor clock; the block's only clock.
REQ-007 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-008 SHALL have port clk_toggle  input  NUM_CH  per-channel toggle, flipped once per usrclk2 cycle in that channel's domain; asynchronous to clk.
REQ-009 SHALL have port ch_enable  input  NUM_CH  per-channel monitor enable, synchronous to clk.
REQ-010 SHALL have port ch_active  output  NUM_CH  per-channel clock-active flag.
REQ-011 SHALL have port all_active  output  1  all enabled channels active.
REQ-012 SHALL have port lost_pulse  output  NUM_CH  one-cycle pulse on ACTIVE-to-LOST transition.

Function
REQ-013 SHALL pass each clk_toggle bit through a 2-flop ASYNC_REG synchroniser, then a third flop; an edge is any difference between flops 2 and 3 (rising or falling).
REQ-014 SHALL run one shared window counter 0..WINDOW-1, wrapping to 0; window_end is asserted when the counter equals WINDOW-1.
REQ-015 SHALL count edges per channel, saturating at all-ones of width clog2(WINDOW+1); an edge on the window_end cycle is included in the closing window; the count restarts at 0 on the following cycle.
REQ-016 SHALL evaluate each channel's window as good or bad only at window_end (qualification rule per REQ-028/029).
REQ-017 SHALL implement a per-channel FSM with states LOST, CHECK, ACTIVE and a good-window counter.
REQ-018 LOST: on good window_end, SHALL go to CHECK with good count 1, or straight to ACTIVE if STABLE_WINDOWS==1; on bad, SHALL stay in LOST.
REQ-019 CHECK: on good window_end, SHALL increment good count and enter ACTIVE when it reaches STABLE_WINDOWS; on bad, SHALL go to LOST with good count 0.
REQ-020 ACTIVE: on bad window_end, SHALL go to LOST, assert lost_pulse for exactly one cycle, and clear the good count.
REQ-021 SHALL force a channel to LOST and clear its edge and good counters on the cycle after ch_enable is low, without a lost_pulse; re-enable SHALL start from the next full window only, with a partial window counting as bad.
REQ-022 SHALL register ch_active as (state==ACTIVE); it SHALL rise one cycle after the qualifying window_end.
REQ-023 SHALL register all_active as the AND of ch_active over enabled channels; it SHALL be 0 when no channel is enabled.
REQ-024 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL all be honoured in the same cycle.

Reset
REQ-025 On rst high at a clk edge, SHALL clear all synchroniser flops, the window counter, edge and good counters, set all FSMs to LOST, and drive ch_active, all_active and lost_pulse to 0 on the next cycle.
REQ-026 Reset mid-window SHALL discard the partial window; counting SHALL restart at window counter 0 on the first cycle after rst deasserts.
REQ-027 No output SHALL depend combinationally on rst or clk_toggle.

Configuration
REQ-028 With USRCLK_MON_FREQ_CHECK_EN defined, a window SHALL be good only if MIN_EDGES <= edge count <= MAX_EDGES, so over- and under-frequency both count as bad.
REQ-029 Without USRCLK_MON_FREQ_CHECK_EN, a window SHALL be good if edge count >= 1; MIN_EDGES and MAX_EDGES are ignored, and edge counters MAY be reduced to 1-bit seen flags.

Verification (NUM_CH=2, WINDOW=16, STABLE_WINDOWS=2, MIN_EDGES=4, MAX_EDGES=12)
REQ-030 Bench SHALL cover: ch0 toggling every 2 clk cycles (8 edges per window), ch_enable=2'b01 -> ch_active[0]=1 one cycle after the 2nd window_end; all_active=1; ch_active[1]=0.
REQ-031 Bench SHALL cover: ch0 ACTIVE, then toggle stopped for a full window -> ch_active[0]=0 and lost_pulse[0]=1 for exactly 1 cycle after that window_end.
REQ-032 Bench SHALL cover: with the macro, ch0 toggling every cycle (16 edges per window) -> ch0 never leaves LOST and ch_active[0] stays 0; without the macro -> ch_active[0]=1 after 2 windows.
REQ-033 Bench SHALL cover: both channels ACTIVE, ch_enable[1] dropped -> ch_active[1]=0 next cycle, lost_pulse[1]=0, all_active stays 1.
REQ-034 Bench SHALL cover: rst pulsed mid-window while both channels are ACTIVE -> all outputs 0 next cycle, ch_active re-asserted exactly 2*16+1 cycles after rst deasserts.
REQ-035 Bench SHALL cover: ch0 with good, bad, good, good windows -> CHECK, LOST, CHECK, ACTIVE, with ch_active[0] rising only after the 4th window.
